// File: rtl/ec_pkg.sv
// Shared definitions for the GF(p) field ALU: opcodes, curve constants, FSM states.
package ec_pkg;

   localparam logic [255:0] SECP256K1_P =
      256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
   localparam logic [255:0] SECP256K1_N =
      256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      FIN  = 2'd2
   } state_t;

endpackage

// File: rtl/ec_mod_addsub.sv
// Combinational modular add/subtract with a single conditional correction.
// Both operands must already be reduced (< MODULUS).
module ec_mod_addsub import ec_pkg::*; #(
   parameter int               WIDTH   = 256,
   parameter logic [WIDTH-1:0] MODULUS = SECP256K1_P
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             sub,
   output logic [WIDTH-1:0] z
);

   localparam logic [WIDTH:0] M_EXT = {1'b0, MODULUS};

   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;
   logic [WIDTH:0] z_full;
   logic           unused_msb;

   // One spare bit holds the carry of x+y and the borrow wrap of x-y.
   always_comb begin
      sum  = {1'b0, x} + {1'b0, y};
      diff = {1'b0, x} - {1'b0, y};
      if (sub)
         z_full = (x >= y) ? diff : diff + M_EXT;
      else
         z_full = (sum >= M_EXT) ? sum - M_EXT : sum;
   end

   assign z          = z_full[WIDTH-1:0];
   assign unused_msb = z_full[WIDTH];

endmodule

// File: rtl/ec_field_alu.sv
// GF(p) add/sub/mul engine with start/busy/done handshake; multiply is
// MSB-first interleaved shift-add, one bit of b per cycle.
module ec_field_alu import ec_pkg::*; #(
   parameter int               WIDTH   = 256,
   parameter logic [WIDTH-1:0] MODULUS = SECP256K1_P
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [1:0]       op_r;
   logic             rej_r;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] cnt;

   logic             reject;
   logic             accept;
   logic             mul_step;
   logic             finish;
   logic [WIDTH-1:0] dbl;
   logic [WIDTH-1:0] add_x;
   logic [WIDTH-1:0] add_y;
   logic             add_sub;
   logic [WIDTH-1:0] add_z;
   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] fin_val;

   assign reject = (a >= MODULUS) || (b >= MODULUS) || (op == OP_RSV);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (reject || op != OP_MUL) ? FIN : MUL;
         MUL:     if (cnt == '0) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != IDLE);
      accept   = (state == IDLE) && start;
      mul_step = (state == MUL);
      finish   = (state == FIN);
   end

   // The second reducer is the mul accumulate stage while multiplying and
   // the add/sub unit otherwise; operands are only ever taken from registers.
   ec_mod_addsub #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_dbl (
      .x   (acc),
      .y   (acc),
      .sub (1'b0),
      .z   (dbl)
   );

   ec_mod_addsub #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_add (
      .x   (add_x),
      .y   (add_y),
      .sub (add_sub),
      .z   (add_z)
   );

   always_comb begin
      if (mul_step) begin
         add_x   = dbl;
         add_y   = a_r;
         add_sub = 1'b0;
      end else begin
         add_x   = a_r;
         add_y   = b_r;
         add_sub = (op_r == OP_SUB);
      end
      step_val = b_r[cnt] ? add_z : dbl;
      if (rej_r)
         fin_val = '0;
      else if (op_r == OP_MUL)
         fin_val = acc;
      else
         fin_val = add_z;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_r   <= '0;
         b_r   <= '0;
         op_r  <= OP_ADD;
         rej_r <= 1'b0;
         acc   <= '0;
         cnt   <= '0;
      end else if (accept) begin
         a_r   <= a;
         b_r   <= b;
         op_r  <= op;
         rej_r <= reject;
         acc   <= '0;
         cnt   <= CNT_W'(WIDTH - 1);
      end else if (mul_step) begin
         acc   <= step_val;
         cnt   <= cnt - CNT_W'(1);
      end
   end

   // Result and err only change on the done edge and hold until the next one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         done <= finish;
         if (finish) begin
            result <= fin_val;
            err    <= rej_r;
         end
      end
   end

endmodule

// File: tb/tb_ec_field_alu.sv
// Bench for ec_field_alu: an 8-bit/251 instance and a default secp256k1 instance,
// checked against arithmetic reference models.
module tb_ec_field_alu;

   localparam logic [255:0] LP = ec_pkg::SECP256K1_P;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic         s_start = 1'b0;
   logic [1:0]   s_op = 2'b00;
   logic [7:0]   s_a = 8'd0;
   logic [7:0]   s_b = 8'd0;
   logic [7:0]   s_result;
   logic         s_busy, s_done, s_err;

   logic         l_start = 1'b0;
   logic [1:0]   l_op = 2'b00;
   logic [255:0] l_a = '0;
   logic [255:0] l_b = '0;
   logic [255:0] l_result;
   logic         l_busy, l_done, l_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ec_field_alu #(.WIDTH(8), .MODULUS(8'd251)) u_small (
      .clk(clk), .reset(reset), .start(s_start), .op(s_op), .a(s_a), .b(s_b),
      .result(s_result), .busy(s_busy), .done(s_done), .err(s_err)
   );

   ec_field_alu u_large (
      .clk(clk), .reset(reset), .start(l_start), .op(l_op), .a(l_a), .b(l_b),
      .result(l_result), .busy(l_busy), .done(l_done), .err(l_err)
   );

   function automatic logic [8:0] s_model(input logic [1:0] op, input int a, input int b);
      int r;
      if (a >= 251 || b >= 251 || op == 2'b11) return {1'b1, 8'd0};
      case (op)
         2'b00:   r = (a + b) % 251;
         2'b01:   r = (a - b + 251) % 251;
         default: r = (a * b) % 251;
      endcase
      return {1'b0, 8'(r)};
   endfunction

   function automatic logic [255:0] l_model(input logic [1:0] op, input logic [255:0] a,
                                            input logic [255:0] b);
      logic [511:0] w;
      logic [511:0] pp;
      pp = {256'b0, LP};
      case (op)
         2'b00:   w = ({256'b0, a} + {256'b0, b}) % pp;
         2'b01:   w = ({256'b0, a} + pp - {256'b0, b}) % pp;
         default: w = ({256'b0, a} * {256'b0, b}) % pp;
      endcase
      return w[255:0];
   endfunction

   task automatic run_s(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output logic e, output int lat);
      s_op = op; s_a = a; s_b = b; s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      s_a = 8'($urandom); s_b = 8'($urandom); s_op = 2'($urandom);
      lat = -1; res = 8'd0; e = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (s_done) begin
            lat = k; res = s_result; e = s_err;
            break;
         end
      end
   endtask

   task automatic run_l(input logic [1:0] op, input logic [255:0] a, input logic [255:0] b,
                        output logic [255:0] res, output logic e, output int lat);
      l_op = op; l_a = a; l_b = b; l_start = 1'b1;
      @(posedge clk); #1;
      l_start = 1'b0;
      l_a = {8{$urandom}}; l_b = {8{$urandom}};
      lat = -1; res = '0; e = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         @(posedge clk); #1;
         if (l_done) begin
            lat = k; res = l_result; e = l_err;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (s_result !== 8'd0) begin errors++; $display("FAIL reset_s_result got %0d exp 0", s_result); end
      checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_s_busy got %0b exp 0", s_busy); end
      checks++; if (s_done !== 1'b0) begin errors++; $display("FAIL reset_s_done got %0b exp 0", s_done); end
      checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL reset_s_err got %0b exp 0", s_err); end
      checks++; if (l_result !== 256'd0) begin errors++; $display("FAIL reset_l_result got %h exp 0", l_result); end
      checks++; if ({l_busy, l_done, l_err} !== 3'b000) begin errors++; $display("FAIL reset_l_flags got %b exp 000", {l_busy, l_done, l_err}); end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_addsub();
      logic [1:0] vop[5];
      int va[5], vb[5], vr[5];
      logic [7:0] res; logic e; int lat;
      vop = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
      va  = '{200, 5, 250, 250, 0};
      vb  = '{100, 10, 250, 0, 0};
      vr  = '{49, 246, 249, 250, 0};
      for (int i = 0; i < 5; i++) begin
         run_s(vop[i], 8'(va[i]), 8'(vb[i]), res, e, lat);
         checks++; if (res !== 8'(vr[i])) begin errors++; $display("FAIL addsub_result[%0d] got %0d exp %0d", i, res, vr[i]); end
         checks++; if (e !== 1'b0) begin errors++; $display("FAIL addsub_err[%0d] got %0b exp 0", i, e); end
         checks++; if (lat !== 1) begin errors++; $display("FAIL addsub_latency[%0d] got %0d exp 1", i, lat); end
      end
   endtask

   task automatic test_mul();
      int va[5], vb[5], vr[5];
      logic [7:0] res; logic e; int lat;
      va = '{7, 200, 0, 250, 1};
      vb = '{9, 200, 250, 250, 250};
      vr = '{63, 91, 0, 1, 250};
      for (int i = 0; i < 5; i++) begin
         run_s(2'b10, 8'(va[i]), 8'(vb[i]), res, e, lat);
         checks++; if (res !== 8'(vr[i])) begin errors++; $display("FAIL mul_result[%0d] got %0d exp %0d", i, res, vr[i]); end
         checks++; if (e !== 1'b0) begin errors++; $display("FAIL mul_err[%0d] got %0b exp 0", i, e); end
         checks++; if (lat !== 9) begin errors++; $display("FAIL mul_latency[%0d] got %0d exp 9", i, lat); end
      end
   endtask

   task automatic test_errors();
      logic [1:0] vop[4];
      int va[4], vb[4];
      logic [7:0] res; logic e; int lat;
      vop = '{2'b00, 2'b10, 2'b11, 2'b01};
      va  = '{251, 5, 10, 255};
      vb  = '{0, 251, 20, 255};
      for (int i = 0; i < 4; i++) begin
         run_s(vop[i], 8'(va[i]), 8'(vb[i]), res, e, lat);
         checks++; if (e !== 1'b1) begin errors++; $display("FAIL errpath_err[%0d] got %0b exp 1", i, e); end
         checks++; if (res !== 8'd0) begin errors++; $display("FAIL errpath_result[%0d] got %0d exp 0", i, res); end
         checks++; if (lat !== 1) begin errors++; $display("FAIL errpath_latency[%0d] got %0d exp 1", i, lat); end
      end
      @(posedge clk); #1;
      checks++; if (s_done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %0b exp 0", s_done); end
      checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL err_holds got %0b exp 1", s_err); end
      checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b exp 0", s_busy); end
      run_s(2'b00, 8'd3, 8'd4, res, e, lat);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL err_clears got %0b exp 0", e); end
      checks++; if (res !== 8'd7) begin errors++; $display("FAIL after_err_result got %0d exp 7", res); end
   endtask

   task automatic test_random();
      logic [1:0] op; logic [7:0] a, b, res; logic e; int lat;
      logic [8:0] m; int exp_lat;
      for (int i = 0; i < 60; i++) begin
         op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         a  = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(251, 255)) : 8'($urandom_range(0, 250));
         b  = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(251, 255)) : 8'($urandom_range(0, 250));
         m = s_model(op, int'(a), int'(b));
         exp_lat = (!m[8] && op == 2'b10) ? 9 : 1;
         run_s(op, a, b, res, e, lat);
         checks++;
         if (res !== m[7:0] || e !== m[8] || lat !== exp_lat) begin
            errors++;
            $display("FAIL random[%0d] op=%0d a=%0d b=%0d got res=%0d err=%0b lat=%0d exp res=%0d err=%0b lat=%0d",
                     i, op, a, b, res, e, lat, m[7:0], m[8], exp_lat);
         end
      end
   endtask

   task automatic test_large();
      logic [255:0] res, a, b, expv; logic e; int lat; logic [1:0] op;
      run_l(2'b10, LP - 1, LP - 1, res, e, lat);
      checks++; if (res !== 256'd1) begin errors++; $display("FAIL large_mul_result got %h exp 1", res); end
      checks++; if (lat !== 257) begin errors++; $display("FAIL large_mul_latency got %0d exp 257", lat); end
      run_l(2'b00, LP - 1, 256'd1, res, e, lat);
      checks++; if (res !== 256'd0 || e !== 1'b0) begin errors++; $display("FAIL large_add_wrap got %h err %0b exp 0 err 0", res, e); end
      run_l(2'b01, 256'd0, 256'd1, res, e, lat);
      checks++; if (res !== LP - 1 || lat !== 1) begin errors++; $display("FAIL large_sub_wrap got %h lat %0d exp %h lat 1", res, lat, LP - 1); end
      run_l(2'b00, LP, 256'd1, res, e, lat);
      checks++; if (e !== 1'b1 || res !== 256'd0) begin errors++; $display("FAIL large_range_err got err %0b res %h exp err 1 res 0", e, res); end
      for (int i = 0; i < 4; i++) begin
         a  = {8{$urandom}} % LP;
         b  = {8{$urandom}} % LP;
         op = 2'($urandom_range(0, 2));
         expv = l_model(op, a, b);
         run_l(op, a, b, res, e, lat);
         checks++;
         if (res !== expv || e !== 1'b0 || lat !== ((op == 2'b10) ? 257 : 1)) begin
            errors++;
            $display("FAIL large_random[%0d] op=%0d got %h lat %0d exp %h", i, op, res, lat, expv);
         end
      end
   endtask

   task automatic test_start_ignored();
      int ndone = 0; int last = -1; logic [7:0] res = 8'd0;
      s_op = 2'b10; s_a = 8'd7; s_b = 8'd9; s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      for (int k = 1; k <= 25; k++) begin
         @(posedge clk); #1;
         if (s_done) begin ndone++; last = k; res = s_result; end
         if (k == 3) begin s_start = 1'b1; s_op = 2'b00; s_a = 8'd1; s_b = 8'd1; end
         if (k == 4) s_start = 1'b0;
      end
      checks++; if (ndone !== 1) begin errors++; $display("FAIL ignored_done_count got %0d exp 1", ndone); end
      checks++; if (last !== 9) begin errors++; $display("FAIL ignored_done_cycle got %0d exp 9", last); end
      checks++; if (res !== 8'd63) begin errors++; $display("FAIL ignored_result got %0d exp 63", res); end
   endtask

   task automatic test_back_to_back();
      int k1 = -1; int k2 = -1; logic [7:0] r1 = 8'd0;
      s_op = 2'b10; s_a = 8'd7; s_b = 8'd9; s_start = 1'b1;
      @(posedge clk); #1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (s_done) begin k1 = k; r1 = s_result; break; end
      end
      checks++; if (k1 !== 9 || r1 !== 8'd63) begin errors++; $display("FAIL b2b_first got lat %0d res %0d exp lat 9 res 63", k1, r1); end
      checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_on_done got %0b exp 0", s_busy); end
      s_a = 8'd3; s_b = 8'd5;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL b2b_reaccept_busy got %0b exp 1", s_busy); end
         end
         if (s_done) begin k2 = k; break; end
      end
      s_start = 1'b0;
      checks++; if (k2 - 1 !== 9) begin errors++; $display("FAIL b2b_latency got %0d exp 9", k2 - 1); end
      checks++; if (s_result !== 8'd15) begin errors++; $display("FAIL b2b_result got %0d exp 15", s_result); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int ndone = 0; logic [7:0] res; logic e; int lat;
      s_op = 2'b10; s_a = 8'd7; s_b = 8'd9; s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      checks++; if (s_result !== 8'd0) begin errors++; $display("FAIL midreset_result got %0d exp 0", s_result); end
      checks++; if ({s_busy, s_done, s_err} !== 3'b000) begin errors++; $display("FAIL midreset_flags got %b exp 000", {s_busy, s_done, s_err}); end
      @(posedge clk); #1;
      reset = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk); #1;
         if (s_done) ndone++;
      end
      checks++; if (ndone !== 0) begin errors++; $display("FAIL midreset_no_done got %0d exp 0", ndone); end
      run_s(2'b10, 8'd7, 8'd9, res, e, lat);
      checks++; if (res !== 8'd63 || lat !== 9) begin errors++; $display("FAIL midreset_recover got %0d lat %0d exp 63 lat 9", res, lat); end
   endtask

   initial begin
      test_reset();
      test_addsub();
      test_mul();
      test_errors();
      test_random();
      test_large();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/ec_field_alu.md
Name: ec_field_alu

Overview:
- Parametrised modular arithmetic unit over GF(p): add, subtract and multiply with a start/done handshake.
- Generalises the fixed 256-bit secp256k1 datapath in width and modulus, and adds operation select, a busy/done handshake and input range checking.
- Serves as the field-operation engine that point-add/point-double sequencers and scalar-multiply controllers issue operations to, one at a time.

Parameters:
- WIDTH, 256, operand/result width in bits.
- MODULUS, 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F (secp256k1 p), field prime.
  - Must satisfy 2 < MODULUS < 2^WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- op  input  2  operation: 00 add, 01 sub, 10 mul, 11 reserved.
- a  input  WIDTH  operand A; must be < MODULUS.
- b  input  WIDTH  operand B; must be < MODULUS.
- result  output  WIDTH  registered result, always in [0, MODULUS-1].
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when result is valid.
- err  output  1  high with done when the operation was rejected.

Behaviour:
- Reset (asynchronous):
  - result=0, busy=0, done=0, err=0, state=IDLE, internal accumulator and counter cleared.
  - Reset asserted mid-operation aborts it; no done pulse follows.
- FSM states: IDLE, MUL, FIN.
- Acceptance: start=1 with busy=0 at edge N. a, b and op are captured at that edge; later input changes have no effect.
- Validation, evaluated at acceptance:
  - Triggers when a >= MODULUS, b >= MODULUS, or op=11.
  - FSM goes to FIN. At edge N+1: done=1, err=1, result=0.
- add/sub:
  - FSM goes to FIN. At edge N+1: done=1, err=0, result valid.
  - Latency is 1 cycle; busy is high for that one cycle.
  - add: s = a + b computed in WIDTH+1 bits; result = s - MODULUS if s >= MODULUS, else s.
  - sub: result = a - b if a >= b, else a - b + MODULUS, computed in WIDTH+1 bits.
- mul: MSB-first interleaved shift-add, one bit of b per cycle.
  - acc=0 and cnt=WIDTH-1 at acceptance; FSM goes to MUL.
  - Per MUL cycle:
    - t = 2*acc; if t >= MODULUS then t -= MODULUS.
    - If b[cnt]=1: u = t + a; if u >= MODULUS then u -= MODULUS; else u = t.
    - acc = u.
  - All intermediates are WIDTH+1 bits.
  - After the cnt=0 step the FSM goes to FIN; result=acc and done=1 at edge N+WIDTH+1. Latency is WIDTH+1 cycles.
- FIN: done pulses for exactly one cycle; busy drops in the same cycle; FSM returns to IDLE.
- Holding start:
  - start while busy=1 is ignored; there is no queueing.
  - start held high continuously re-accepts on the first cycle busy=0, i.e. the cycle done is high. Back-to-back operations therefore have one idle-free gap: done and the next acceptance coincide.
- result holds its value until the next done. err holds until the next done.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package ec_pkg:
  - op encoding constants OP_ADD, OP_SUB, OP_MUL.
  - Default SECP256K1_P and SECP256K1_N constants.
  - FSM state typedef.
- One sub-module, ec_mod_addsub: a combinational conditional-subtract reducer (x + y mod p, x - y mod p).
  - Instantiated twice in the MUL step (doubling, addition) and shared by the add/sub path.

Test Plan:
- WIDTH=8, MODULUS=251: add a=200, b=100 -> done at N+1, result=49, err=0. Sub a=5, b=10 -> result=246.
- WIDTH=8, MODULUS=251: mul a=7, b=9 -> done exactly 9 cycles after acceptance, result=63. Mul a=200, b=200 -> result=91. Mul a=0, b=250 -> result=0.
- Default params: mul a=p-1, b=p-1 -> result=1 after 257 cycles. Add a=p-1, b=1 -> result=0. Sub a=0, b=1 -> result=p-1.
- Error paths: a=251 (WIDTH=8) -> done at N+1, err=1, result=0. op=11 with valid operands -> err=1.
- Handshake:
  - start pulsed during an active mul is ignored; exactly one done occurs.
  - start held high across two muls -> second acceptance on the done cycle, second done 9 cycles later.
- Reset mid-mul at cycle 4 -> all outputs 0 immediately (asynchronous). No done afterwards. A new mul 7*9 then returns 63.
